// File: rtl/axi4_lite_regs_if.sv
// AXI4-Lite bus bundle for axi4_lite_regs: the five channels grouped with
// manager-side (master) and subordinate-side (slave) views.
interface axi4_lite_regs_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_regs.sv
// AXI4-Lite subordinate with NUM_REGS parallel-out control registers and per-register write pulses.
// Define AXI4_LITE_REGS_PROT_EN to answer unprivileged accesses (prot[0]=0) with SLVERR.
module axi4_lite_regs #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  axi4_lite_regs_if.slave           bus,
  output logic [NUM_REGS*WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]       wr_pulse
);
  localparam int NB = WIDTH / 8;
  localparam int AL = $clog2(NB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr >> AL);
  endfunction

  logic                  ready_en_q;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awpriv_q, awpriv_d;
  logic                  w_held_q, w_held_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [WIDTH-1:0]      regs_q [NUM_REGS];
  logic [WIDTH-1:0]      regs_d [NUM_REGS];
  logic                  rvalid_q, rvalid_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic                  aw_priv_s, ar_priv_s;
  logic [ADDR_WIDTH-1:0] cm_addr_s;
  logic                  cm_priv_s, cm_ok_s;
  logic [31:0]           cm_idx_s, ar_idx_s;
  logic [WIDTH-1:0]      cm_data_s, rd_mux_s;
  logic [NB-1:0]         cm_strb_s;
  logic                  ar_ok_s;
  logic [NUM_REGS-1:0]   wr_sel_s;
  logic                  unused_s;

`ifdef AXI4_LITE_REGS_PROT_EN
  assign aw_priv_s = bus.awprot[0];
  assign ar_priv_s = bus.arprot[0];
`else
  assign aw_priv_s = 1'b1;
  assign ar_priv_s = 1'b1;
`endif
  assign unused_s = ^{bus.awprot, bus.arprot};

  // Readies come from registered state only; ready_en_q keeps them low through reset.
  assign bus.awready = ready_en_q && !aw_held_q && !bvalid_q;
  assign bus.wready  = ready_en_q && !w_held_q && !bvalid_q;
  assign bus.arready = ready_en_q && !rvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

  assign aw_hs_s   = bus.awvalid && bus.awready;
  assign w_hs_s    = bus.wvalid && bus.wready;
  assign ar_hs_s   = bus.arvalid && bus.arready;
  assign commit_s  = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
  assign cm_addr_s = aw_held_q ? awaddr_q : bus.awaddr;
  assign cm_priv_s = aw_held_q ? awpriv_q : aw_priv_s;
  assign cm_data_s = w_held_q ? wdata_q : bus.wdata;
  assign cm_strb_s = w_held_q ? wstrb_q : bus.wstrb;
  assign cm_idx_s  = reg_index(cm_addr_s);
  assign cm_ok_s   = (cm_idx_s < 32'(NUM_REGS)) && cm_priv_s;
  assign ar_idx_s  = reg_index(bus.araddr);
  assign ar_ok_s   = (ar_idx_s < 32'(NUM_REGS)) && ar_priv_s;

  always_comb begin
    wr_sel_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel_s[i] = commit_s && cm_ok_s && (cm_idx_s == 32'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int b = 0; b < NB; b++) begin
        regs_d[i][b*8 +: 8] = (wr_sel_s[i] && cm_strb_s[b]) ? cm_data_s[b*8 +: 8]
                                                             : regs_q[i][b*8 +: 8];
      end
    end
    wr_pulse_d = wr_sel_s & {NUM_REGS{|cm_strb_s}};
  end

  // Capture flags and B channel: a commit consumes both captures and raises bvalid.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    awpriv_d  = awpriv_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = cm_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = bus.awaddr;
        awpriv_d  = aw_priv_s;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = bus.wdata;
        wstrb_d  = bus.wstrb;
      end else begin
        w_held_d = w_held_q;
      end
      if (bvalid_q && bus.bready) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_mux_s = rd_mux_s | ((ar_ok_s && (ar_idx_s == 32'(i))) ? regs_q[i] : {WIDTH{1'b0}});
    end
  end

  // Read data samples regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_s;
      rresp_d  = ar_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_comb begin
    reg_q = {(NUM_REGS*WIDTH){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= {ADDR_WIDTH{1'b0}};
      awpriv_q   <= 1'b0;
      w_held_q   <= 1'b0;
      wdata_q    <= {WIDTH{1'b0}};
      wstrb_q    <= {NB{1'b0}};
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= {NUM_REGS{1'b0}};
      rvalid_q   <= 1'b0;
      rdata_q    <= {WIDTH{1'b0}};
      rresp_q    <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      awpriv_q   <= awpriv_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end
endmodule
